// File: rtl/lp805x_synctrl_pkg.sv
// Shared definitions for the lp805x multi-channel SFR get/put handshake controller:
// state encoding, legal parameter ranges and the timeout counter width helper.
package lp805x_synctrl_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_GET  = 2'd1;
   localparam state_t ST_PUT  = 2'd2;

   localparam int CHANNELS_MIN  = 1;
   localparam int CHANNELS_MAX  = 16;
   localparam int PUT_DELAY_MIN = 1;
   localparam int PUT_DELAY_MAX = 8;
   localparam int TIMEOUT_MIN   = 2;
   localparam int TIMEOUT_MAX   = 65535;

   function automatic int cnt_width(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/lp805x_synctrl_if.sv
// Per-channel handshake, flag and busy signals between the CPU/peripheral side
// (master) and the lp805x_synctrl_mc controller (slave).
interface lp805x_synctrl_if #(
   parameter int CHANNELS = 4
);

   logic [CHANNELS-1:0] read;
   logic [CHANNELS-1:0] sfr_prrdy;
   logic [CHANNELS-1:0] sfr_pwrdy;
   logic [CHANNELS-1:0] sfr_pget;
   logic [CHANNELS-1:0] sfr_pput;
   logic [CHANNELS-1:0] ovr_clr;
   logic [CHANNELS-1:0] sfr_ovr;
   logic [CHANNELS-1:0] tmo_clr;
   logic [CHANNELS-1:0] sfr_tmo;
   logic                sfr_busy;

   modport master (
      output read, sfr_prrdy, sfr_pwrdy, ovr_clr, tmo_clr,
      input  sfr_pget, sfr_pput, sfr_ovr, sfr_tmo, sfr_busy
   );

   modport slave (
      input  read, sfr_prrdy, sfr_pwrdy, ovr_clr, tmo_clr,
      output sfr_pget, sfr_pput, sfr_ovr, sfr_tmo, sfr_busy
   );

endinterface

// File: rtl/lp805x_synctrl_ch.sv
// Single handshake channel: IDLE/GET/PUT FSM, put delay line, sticky overrun flag
// and, with LP805X_SYNCTRL_TIMEOUT_EN defined, the stall counter and timeout flag.
module lp805x_synctrl_ch
   import lp805x_synctrl_pkg::*;
#(
   parameter int PUT_DELAY = 2,
   parameter int TIMEOUT   = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic read,
   input  logic prrdy,
   input  logic pwrdy,
   input  logic ovr_clr,
   input  logic tmo_clr,
   output logic pget,
   output logic pput,
   output logic ovr,
   output logic tmo,
   output logic busy
);

   state_t               state;
   logic [PUT_DELAY-1:0] dly;
   logic                 accept;
   logic                 launch;
   logic                 tmo_hit;

   assign accept = (state == ST_GET) & read & pwrdy;
   // The token enters the delay line one cycle after accept, so the pulse lands
   // PUT_DELAY edges after the accepting edge.
   assign launch = (state == ST_PUT) & ~|dly;

   assign pget = (state == ST_GET);
   assign pput = dly[PUT_DELAY-1];
   assign busy = pget | (state == ST_PUT);

`ifdef LP805X_SYNCTRL_TIMEOUT_EN
   localparam int CW = cnt_width(TIMEOUT);

   logic [CW-1:0] cnt;

   assign tmo_hit = (state == ST_GET) & (cnt == CW'(TIMEOUT - 1)) & ~prrdy & ~accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         tmo <= 1'b0;
      end else begin
         if (prrdy || state != ST_GET)
            cnt <= '0;
         else if (cnt != {CW{1'b1}})
            cnt <= cnt + 1'b1;

         if (tmo_hit)
            tmo <= 1'b1;
         else if (tmo_clr)
            tmo <= 1'b0;
      end
   end
`else
   logic unused_cfg;

   assign unused_cfg = tmo_clr ^ (TIMEOUT == 0);
   assign tmo_hit    = 1'b0;
   assign tmo        = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         dly   <= '0;
         ovr   <= 1'b0;
      end else begin
         if (prrdy) begin
            state <= ST_GET;
            dly   <= '0;
         end else if (accept) begin
            state <= ST_PUT;
            dly   <= '0;
         end else if (tmo_hit) begin
            state <= ST_IDLE;
         end else if (state == ST_PUT) begin
            dly <= (dly << 1) | PUT_DELAY'(launch);
            if (dly[PUT_DELAY-1])
               state <= ST_IDLE;
         end else if (state != ST_IDLE && state != ST_GET) begin
            state <= ST_IDLE;
         end

         if (prrdy && state == ST_GET)
            ovr <= 1'b1;
         else if (ovr_clr)
            ovr <= 1'b0;
      end
   end

endmodule

// File: rtl/lp805x_synctrl_mc.sv
// Multi-channel SFR transfer handshake controller: CHANNELS independent get/put
// channels reduced to one busy flag. Optional stall timeout: LP805X_SYNCTRL_TIMEOUT_EN.
module lp805x_synctrl_mc
   import lp805x_synctrl_pkg::*;
#(
   parameter int CHANNELS  = 4,
   parameter int PUT_DELAY = 2,
   parameter int TIMEOUT   = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   lp805x_synctrl_if.slave      bus
);

   generate
      if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
         $error("lp805x_synctrl_mc: CHANNELS out of range");
      end
      if (PUT_DELAY < PUT_DELAY_MIN || PUT_DELAY > PUT_DELAY_MAX) begin : g_bad_delay
         $error("lp805x_synctrl_mc: PUT_DELAY out of range");
      end
`ifdef LP805X_SYNCTRL_TIMEOUT_EN
      if (TIMEOUT < TIMEOUT_MIN || TIMEOUT > TIMEOUT_MAX) begin : g_bad_timeout
         $error("lp805x_synctrl_mc: TIMEOUT out of range");
      end
`endif
   endgenerate

   logic [CHANNELS-1:0] pget;
   logic [CHANNELS-1:0] pput;
   logic [CHANNELS-1:0] ovr;
   logic [CHANNELS-1:0] tmo;
   logic [CHANNELS-1:0] busy;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      lp805x_synctrl_ch #(
         .PUT_DELAY (PUT_DELAY),
         .TIMEOUT   (TIMEOUT)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .read    (bus.read[i]),
         .prrdy   (bus.sfr_prrdy[i]),
         .pwrdy   (bus.sfr_pwrdy[i]),
         .ovr_clr (bus.ovr_clr[i]),
         .tmo_clr (bus.tmo_clr[i]),
         .pget    (pget[i]),
         .pput    (pput[i]),
         .ovr     (ovr[i]),
         .tmo     (tmo[i]),
         .busy    (busy[i])
      );
   end

   assign bus.sfr_pget = pget;
   assign bus.sfr_pput = pput;
   assign bus.sfr_ovr  = ovr;
   assign bus.sfr_tmo  = tmo;
   assign bus.sfr_busy = |busy;

endmodule

// File: tb/tb_lp805x_synctrl_mc.sv
// Bench for lp805x_synctrl_mc: directed vector table, timeout sequence and
// randomized traffic against a transaction-level reference model.
module tb_lp805x_synctrl_mc;

   localparam int CH  = 4;
   localparam int PD  = 2;
   localparam int TMO = 8;
`ifdef LP805X_SYNCTRL_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   lp805x_synctrl_if #(.CHANNELS(CH)) bus ();

   lp805x_synctrl_mc #(
      .CHANNELS  (CH),
      .PUT_DELAY (PD),
      .TIMEOUT   (TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   int edge_n = 0;

   // Reference model: pending get, cycles spent pending, edge at which the put fires.
   bit m_get [CH];
   int m_age [CH];
   int m_due [CH];
   bit m_ovr [CH];
   bit m_tmo [CH];

   typedef struct {
      logic       r;
      logic [3:0] prrdy, read, pwrdy, oclr;
      logic [3:0] pget, pput, ovr;
      logic       busy;
   } vec_t;

   vec_t vt [40];

   function automatic vec_t mk(input logic r, input logic [3:0] pr, input logic [3:0] rd,
                               input logic [3:0] pw, input logic [3:0] oc, input logic [3:0] g,
                               input logic [3:0] p, input logic [3:0] o, input logic b);
      vec_t v;
      v.r = r; v.prrdy = pr; v.read = rd; v.pwrdy = pw; v.oclr = oc;
      v.pget = g; v.pput = p; v.ovr = o; v.busy = b;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   task automatic model_edge();
      edge_n++;
      for (int i = 0; i < CH; i++) begin
         bit pr, had, acc, tev;
         pr  = bus.sfr_prrdy[i];
         had = m_get[i];
         acc = had && bus.read[i] && bus.sfr_pwrdy[i];
         tev = TMO_EN && had && (m_age[i] >= TMO) && !pr && !acc;
         if (rst) begin
            m_get[i] = 0; m_age[i] = 0; m_due[i] = -1; m_ovr[i] = 0; m_tmo[i] = 0;
         end else begin
            if (pr) begin
               m_get[i] = 1; m_age[i] = 1; m_due[i] = -1;
            end else if (acc) begin
               m_get[i] = 0; m_due[i] = edge_n + PD;
            end else if (tev) begin
               m_get[i] = 0;
            end else if (had) begin
               m_age[i]++;
            end
            if (pr && had) m_ovr[i] = 1;
            else if (bus.ovr_clr[i]) m_ovr[i] = 0;
            if (tev) m_tmo[i] = 1;
            else if (bus.tmo_clr[i]) m_tmo[i] = 0;
         end
      end
   endtask

   task automatic step();
      logic [CH-1:0] e_get, e_put, e_ovr, e_tmo;
      logic          e_busy;
      @(posedge clk);
      model_edge();
      #1;
      e_busy = 1'b0;
      for (int i = 0; i < CH; i++) begin
         e_get[i] = m_get[i];
         e_put[i] = (m_due[i] == edge_n);
         e_ovr[i] = m_ovr[i];
         e_tmo[i] = m_tmo[i];
         if (m_get[i] || m_due[i] >= edge_n) e_busy = 1'b1;
      end
      chk("model_pget", 32'(bus.sfr_pget), 32'(e_get));
      chk("model_pput", 32'(bus.sfr_pput), 32'(e_put));
      chk("model_ovr",  32'(bus.sfr_ovr),  32'(e_ovr));
      chk("model_tmo",  32'(bus.sfr_tmo),  32'(e_tmo));
      chk("model_busy", 32'(bus.sfr_busy), 32'(e_busy));
   endtask

   task automatic idle_inputs();
      rst           = 1'b0;
      bus.read      = '0;
      bus.sfr_prrdy = '0;
      bus.sfr_pwrdy = '0;
      bus.ovr_clr   = '0;
      bus.tmo_clr   = '0;
   endtask

   initial begin
      logic [3:0] seen;

      for (int i = 0; i < CH; i++) m_due[i] = -1;

      //             rst prrdy read pwrdy oclr | pget pput ovr busy
      vt[0]  = mk(0, 4'h1, 4'h0, 4'h0, 4'h0,  4'h1, 4'h0, 4'h0, 1);
      vt[1]  = mk(0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h1, 4'h0, 4'h0, 1);
      vt[2]  = mk(0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h1, 4'h0, 4'h0, 1);
      vt[3]  = mk(0, 4'h0, 4'h1, 4'h1, 4'h0,  4'h0, 4'h0, 4'h0, 1);
      vt[4]  = mk(0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 4'h0, 1);
      vt[5]  = mk(0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h1, 4'h0, 1);
      vt[6]  = mk(0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 4'h0, 0);
      vt[7]  = mk(0, 4'h2, 4'h0, 4'h0, 4'h0,  4'h2, 4'h0, 4'h0, 1);
      vt[8]  = mk(0, 4'h2, 4'h0, 4'h0, 4'h0,  4'h2, 4'h0, 4'h2, 1);
      vt[9]  = mk(0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h2, 4'h0, 4'h2, 1);
      vt[10] = mk(0, 4'h0, 4'h0, 4'h0, 4'h2,  4'h2, 4'h0, 4'h0, 1);
      vt[11] = mk(0, 4'h2, 4'h0, 4'h0, 4'h2,  4'h2, 4'h0, 4'h2, 1);
      vt[12] = mk(0, 4'h0, 4'h0, 4'h0, 4'h2,  4'h2, 4'h0, 4'h0, 1);
      vt[13] = mk(1, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 4'h0, 0);
      vt[14] = mk(0, 4'h4, 4'h0, 4'h0, 4'h0,  4'h4, 4'h0, 4'h0, 1);
      vt[15] = mk(0, 4'h0, 4'h4, 4'h4, 4'h0,  4'h0, 4'h0, 4'h0, 1);
      vt[16] = mk(0, 4'h4, 4'h0, 4'h0, 4'h0,  4'h4, 4'h0, 4'h0, 1);
      vt[17] = mk(0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h4, 4'h0, 4'h0, 1);
      vt[18] = mk(0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h4, 4'h0, 4'h0, 1);
      vt[19] = mk(1, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 4'h0, 0);
      vt[20] = mk(0, 4'h9, 4'h0, 4'h0, 4'h0,  4'h9, 4'h0, 4'h0, 1);
      vt[21] = mk(0, 4'h0, 4'h9, 4'h9, 4'h0,  4'h0, 4'h0, 4'h0, 1);
      vt[22] = mk(0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 4'h0, 1);
      vt[23] = mk(0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h9, 4'h0, 1);
      vt[24] = mk(0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 4'h0, 0);
      vt[25] = mk(0, 4'h9, 4'h0, 4'h0, 4'h0,  4'h9, 4'h0, 4'h0, 1);
      vt[26] = mk(0, 4'h0, 4'h9, 4'h9, 4'h0,  4'h0, 4'h0, 4'h0, 1);
      vt[27] = mk(1, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 4'h0, 0);
      vt[28] = mk(0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 4'h0, 0);
      vt[29] = mk(0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 4'h0, 0);
      vt[30] = mk(0, 4'h1, 4'h0, 4'h0, 4'h0,  4'h1, 4'h0, 4'h0, 1);
      vt[31] = mk(0, 4'h1, 4'h1, 4'h1, 4'h0,  4'h1, 4'h0, 4'h1, 1);
      vt[32] = mk(0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h1, 4'h0, 4'h1, 1);
      vt[33] = mk(0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h1, 4'h0, 4'h1, 1);
      vt[34] = mk(1, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 4'h0, 0);
      vt[35] = mk(0, 4'h2, 4'h0, 4'h0, 4'h0,  4'h2, 4'h0, 4'h0, 1);
      vt[36] = mk(0, 4'h0, 4'h2, 4'h0, 4'h0,  4'h2, 4'h0, 4'h0, 1);
      vt[37] = mk(0, 4'h0, 4'h0, 4'h2, 4'h0,  4'h2, 4'h0, 4'h0, 1);
      vt[38] = mk(1, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 4'h0, 0);
      vt[39] = mk(0, 4'h0, 4'hF, 4'hF, 4'h0,  4'h0, 4'h0, 4'h0, 0);

      idle_inputs();
      rst = 1'b1;
      step();
      step();
      chk("reset_outputs", {bus.sfr_pget, bus.sfr_pput, bus.sfr_ovr, bus.sfr_tmo, 3'b0, bus.sfr_busy}, 32'h0);

      for (int i = 0; i < 40; i++) begin
         idle_inputs();
         rst           = vt[i].r;
         bus.sfr_prrdy = vt[i].prrdy;
         bus.read      = vt[i].read;
         bus.sfr_pwrdy = vt[i].pwrdy;
         bus.ovr_clr   = vt[i].oclr;
         step();
         chk($sformatf("v%0d_pget", i), 32'(bus.sfr_pget), 32'(vt[i].pget));
         chk($sformatf("v%0d_pput", i), 32'(bus.sfr_pput), 32'(vt[i].pput));
         chk($sformatf("v%0d_ovr", i),  32'(bus.sfr_ovr),  32'(vt[i].ovr));
         chk($sformatf("v%0d_tmo", i),  32'(bus.sfr_tmo),  32'h0);
         chk($sformatf("v%0d_busy", i), 32'(bus.sfr_busy), 32'(vt[i].busy));
      end

      // Stalled get on channel 3 with no read.
      idle_inputs();
      bus.sfr_prrdy = 4'h8;
      step();
      chk("stall_entry_pget3", 32'(bus.sfr_pget[3]), 32'h1);
      idle_inputs();
      for (int k = 0; k < 7; k++) begin
         step();
         chk($sformatf("stall_hold%0d_pget3", k), 32'(bus.sfr_pget[3]), 32'h1);
      end
      seen = '0;
`ifdef LP805X_SYNCTRL_TIMEOUT_EN
      bus.tmo_clr = 4'h8;
      step();
      chk("tmo_drop_pget3", 32'(bus.sfr_pget[3]), 32'h0);
      chk("tmo_set_wins",   32'(bus.sfr_tmo),     32'h8);
      step();
      chk("tmo_clear",      32'(bus.sfr_tmo),     32'h0);
      idle_inputs();
      for (int k = 0; k < 100; k++) begin
         step();
         seen = seen | bus.sfr_pput;
      end
      chk("tmo_no_put", 32'(seen), 32'h0);
`else
      bus.tmo_clr = 4'h8;
      for (int k = 0; k < 100; k++) begin
         step();
         if (bus.sfr_pget[3] !== 1'b1 || bus.sfr_tmo !== 4'h0 || bus.sfr_pput[3] !== 1'b0)
            seen[0] = 1'b1;
      end
      chk("no_tmo_hold_100", 32'(seen), 32'h0);
      chk("no_tmo_flag",     32'(bus.sfr_tmo), 32'h0);
`endif

      // Randomized traffic, first with eager readers, then with slow ones.
      for (int k = 0; k < 3000; k++) begin
         idle_inputs();
         rst = ($urandom_range(0, 199) == 0);
         for (int i = 0; i < CH; i++) begin
            bus.sfr_prrdy[i] = ($urandom_range(0, 9) == 0);
            bus.read[i]      = (k < 1500) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) == 0);
            bus.sfr_pwrdy[i] = ($urandom_range(0, 2) != 0);
            bus.ovr_clr[i]   = ($urandom_range(0, 9) == 0);
            bus.tmo_clr[i]   = ($urandom_range(0, 9) == 0);
         end
         step();
      end

      idle_inputs();
      rst = 1'b1;
      step();
      chk("final_reset_busy", 32'(bus.sfr_busy), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
